// File: rtl/pipe3_cpu.sv
// Three-stage (IF, ID/EX, WB) toy CPU with a 2-bit opcode, full EX/WB forwarding and a sticky HALT.
// Instruction memory is not reset; the register file resets to Reg[i] = i+1.
module pipe3_cpu #(
  parameter  int DW         = 8,
  parameter  int NREG       = 8,
  parameter  int IMEM_DEPTH = 16,
  localparam int RAW        = $clog2(NREG),
  localparam int PAW        = $clog2(IMEM_DEPTH),
  localparam int IW         = 2 + 2 * RAW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic           prog_we,
  input  logic [PAW-1:0] prog_addr,
  input  logic [IW-1:0]  prog_data,
  input  logic [RAW-1:0] dbg_addr,
  output logic [DW-1:0]  dbg_data,
  output logic [PAW-1:0] pc,
  output logic           halted,
  output logic           wb_valid,
  output logic [RAW-1:0] wb_addr,
  output logic [DW-1:0]  wb_data
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  logic [IW-1:0]  imem [IMEM_DEPTH];
  logic [DW-1:0]  regs [NREG];

  logic           ifid_valid;
  logic [IW-1:0]  ifid_instr;

  logic [1:0]     op;
  logic [RAW-1:0] rd;
  logic [RAW-1:0] rs;
  logic [DW-1:0]  opa;
  logic [DW-1:0]  opb;
  logic [DW-1:0]  alu;
  logic           advance;
  logic           exec;
  logic           halt_now;

  assign op = ifid_instr[IW-1 -: 2];
  assign rd = ifid_instr[2*RAW-1 -: RAW];
  assign rs = ifid_instr[RAW-1:0];

  // The EX/WB entry commits on the same edge the next instruction executes, so bypass it.
  assign opa = (wb_valid && (wb_addr == rd)) ? wb_data : regs[rd];
  assign opb = (wb_valid && (wb_addr == rs)) ? wb_data : regs[rs];

  assign advance  = run && !halted;
  assign exec     = advance && ifid_valid;
  assign halt_now = exec && (op == OP_HALT);

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = opa + opb;
      OP_SRL:  alu = ({1'b0, opb} >= (DW+1)'(DW)) ? '0 : (opa >> opb);
      OP_SUB:  alu = opa - opb;
      default: alu = '0;
    endcase
  end

  assign dbg_data = regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (prog_we) begin
      imem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= DW'(i + 1);
      end
    end else if (wb_valid) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= '0;
      halted     <= 1'b0;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
    end else begin
      wb_valid <= exec && !halt_now;
      if (exec && !halt_now) begin
        wb_addr <= rd;
        wb_data <= alu;
      end
      if (halt_now) begin
        halted     <= 1'b1;
        ifid_valid <= 1'b0;
      end else if (advance) begin
        pc         <= pc + 1'b1;
        ifid_valid <= 1'b1;
        ifid_instr <= imem[pc];
      end
    end
  end

endmodule
